// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state encoding, operation codes and default widths for the ATM balance arbiter
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LEER      = 2'd1,
    VERIFICAR = 2'd2,
    RESPONDER = 2'd3
  } atm_state_t;

  localparam logic OP_RETIRO   = 1'b1;
  localparam logic OP_DEPOSITO = 1'b0;

  localparam int DEF_MONTO_W = 32;
  localparam int DEF_BAL_W   = 64;

endpackage

// File: rtl/atm_cuenta_arbiter_if.sv
// rtl/atm_cuenta_arbiter_if.sv - request/response bundle between ATM front-ends and the balance arbiter
interface atm_cuenta_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int AW      = 3,
  parameter int MONTO_W = 32,
  parameter int BAL_W   = 64
);
  logic [N_REQ-1:0]         REQ;
  logic [N_REQ-1:0]         REQ_TIPO;
  logic [N_REQ-1:0]         REQ_FORANEA;
  logic [N_REQ*AW-1:0]      REQ_CUENTA;
  logic [N_REQ*MONTO_W-1:0] REQ_MONTO;
  logic                     LOAD_STB;
  logic [AW-1:0]            LOAD_CUENTA;
  logic [BAL_W-1:0]         LOAD_VALOR;
  logic [N_REQ-1:0]         GNT;
  logic [N_REQ-1:0]         DONE;
  logic                     DONE_OK;
  logic [BAL_W-1:0]         BALANCE_OUT;
  logic                     LOAD_ACK;
  logic                     OCUPADO;

  // Front-end side: terminals and the balance loader.
  modport master (
    output REQ, REQ_TIPO, REQ_FORANEA, REQ_CUENTA, REQ_MONTO,
    output LOAD_STB, LOAD_CUENTA, LOAD_VALOR,
    input  GNT, DONE, DONE_OK, BALANCE_OUT, LOAD_ACK, OCUPADO
  );

  // Arbiter side.
  modport slave (
    input  REQ, REQ_TIPO, REQ_FORANEA, REQ_CUENTA, REQ_MONTO,
    input  LOAD_STB, LOAD_CUENTA, LOAD_VALOR,
    output GNT, DONE, DONE_OK, BALANCE_OUT, LOAD_ACK, OCUPADO
  );

endinterface

// File: rtl/atm_rr_arbiter.sv
// rtl/atm_rr_arbiter.sv - combinational round-robin pick: first set request at or after the pointer
module atm_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] sel,
  output logic             valid
);

  logic [PW-1:0] j;

  // Scan from the pointer, wrapping, and keep only the first hit.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = PW'((int'(ptr) + k) % N_REQ);
      if (!valid && req[j]) begin
        sel[j] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_cuenta_arbiter.sv
// rtl/atm_cuenta_arbiter.sv - round-robin read-check-write owner of the account balances; ATM_ARB_COMISION_EN adds the foreign-card fee
module atm_cuenta_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_CUENTAS = 8,
  parameter int AW        = 3,
  parameter int MONTO_W   = DEF_MONTO_W,
  parameter int BAL_W     = DEF_BAL_W,
  parameter int COMISION  = 2
) (
  input logic              CLK,
  input logic              RESET,
  atm_cuenta_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);

  atm_state_t       estado;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    idx_q;
  logic [N_REQ-1:0] sel_q;
  logic             tipo_q;
  logic [AW-1:0]    cuenta_q;
  logic [MONTO_W-1:0] monto_q;
  logic [BAL_W-1:0] trabajo_q;
  logic [BAL_W-1:0] saldo [N_CUENTAS];

  logic [N_REQ-1:0]   sel_oh;
  logic               sel_valid;
  logic [PW-1:0]      sel_idx;
  logic               sel_tipo;
  logic               sel_foranea;
  logic [AW-1:0]      sel_cuenta;
  logic [MONTO_W-1:0] sel_monto;

  logic [BAL_W:0]   monto_ext;
  logic [BAL_W:0]   requerido;
  logic [BAL_W:0]   suma;
  logic             aplicado;
  logic [BAL_W-1:0] nuevo;

`ifdef ATM_ARB_COMISION_EN
  logic foranea_q;
`else
  wire unused_foranea = sel_foranea;
  localparam int unused_comision = COMISION;
`endif

  atm_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req   (bus.REQ),
    .ptr   (ptr),
    .sel   (sel_oh),
    .valid (sel_valid)
  );

  // Extract the winning terminal's index and operands from the packed request buses.
  always_comb begin
    sel_idx     = '0;
    sel_tipo    = 1'b0;
    sel_foranea = 1'b0;
    sel_cuenta  = '0;
    sel_monto   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_idx     = PW'(i);
        sel_tipo    = bus.REQ_TIPO[i];
        sel_foranea = bus.REQ_FORANEA[i];
        sel_cuenta  = bus.REQ_CUENTA[i*AW +: AW];
        sel_monto   = bus.REQ_MONTO[i*MONTO_W +: MONTO_W];
      end
    end
  end

  // Check and compute the new balance; one extra bit catches deposit overflow and oversized debits.
  always_comb begin
    monto_ext                = '0;
    monto_ext[MONTO_W-1:0]   = monto_q;
    requerido                = monto_ext;
`ifdef ATM_ARB_COMISION_EN
    if (foranea_q) requerido = monto_ext + (BAL_W+1)'(COMISION);
`endif
    suma     = {1'b0, trabajo_q} + monto_ext;
    aplicado = 1'b1;
    nuevo    = trabajo_q;
    case (tipo_q)
      OP_RETIRO: begin
        aplicado = ({1'b0, trabajo_q} >= requerido);
        if (aplicado) nuevo = trabajo_q - requerido[BAL_W-1:0];
      end
      OP_DEPOSITO: begin
        nuevo = suma[BAL_W] ? {BAL_W{1'b1}} : suma[BAL_W-1:0];
      end
    endcase
  end

  // Transaction sequencer, balance storage and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      estado          <= IDLE;
      ptr             <= '0;
      idx_q           <= '0;
      sel_q           <= '0;
      tipo_q          <= 1'b0;
      cuenta_q        <= '0;
      monto_q         <= '0;
      trabajo_q       <= '0;
`ifdef ATM_ARB_COMISION_EN
      foranea_q       <= 1'b0;
`endif
      for (int c = 0; c < N_CUENTAS; c++) saldo[c] <= '0;
      bus.GNT         <= '0;
      bus.DONE        <= '0;
      bus.DONE_OK     <= 1'b0;
      bus.BALANCE_OUT <= '0;
      bus.LOAD_ACK    <= 1'b0;
      bus.OCUPADO     <= 1'b0;
    end else begin
      bus.GNT      <= '0;
      bus.DONE     <= '0;
      bus.LOAD_ACK <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.LOAD_STB) begin
            saldo[bus.LOAD_CUENTA] <= bus.LOAD_VALOR;
            bus.LOAD_ACK           <= 1'b1;
          end else if (sel_valid) begin
            bus.GNT     <= sel_oh;
            sel_q       <= sel_oh;
            idx_q       <= sel_idx;
            tipo_q      <= sel_tipo;
            cuenta_q    <= sel_cuenta;
            monto_q     <= sel_monto;
`ifdef ATM_ARB_COMISION_EN
            foranea_q   <= sel_foranea;
`endif
            bus.OCUPADO <= 1'b1;
            estado      <= LEER;
          end
        end
        LEER: begin
          trabajo_q <= saldo[cuenta_q];
          estado    <= VERIFICAR;
        end
        VERIFICAR: begin
          if (aplicado) saldo[cuenta_q] <= nuevo;
          bus.DONE        <= sel_q;
          bus.DONE_OK     <= aplicado;
          bus.BALANCE_OUT <= nuevo;
          estado          <= RESPONDER;
        end
        RESPONDER: begin
          ptr         <= (idx_q == PW'(N_REQ-1)) ? '0 : idx_q + PW'(1);
          bus.OCUPADO <= 1'b0;
          estado      <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_cuenta_arbiter.sv
// tb/tb_atm_cuenta_arbiter.sv - scoreboard bench for atm_cuenta_arbiter with a transaction-level balance model
module tb_atm_cuenta_arbiter;
  localparam int N_REQ = 4, N_CUENTAS = 8, AW = 3, MONTO_W = 32, BAL_W = 64, COMISION = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  atm_cuenta_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .MONTO_W(MONTO_W), .BAL_W(BAL_W)) bus ();

  atm_cuenta_arbiter #(
    .N_REQ(N_REQ), .N_CUENTAS(N_CUENTAS), .AW(AW),
    .MONTO_W(MONTO_W), .BAL_W(BAL_W), .COMISION(COMISION)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    int          term;
    int          cyc;
    bit          ok;
    logic [63:0] bal;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  int   lq[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [63:0] bal_m [N_CUENTAS];
  int          ptr_m = 0;
  bit          last_ok = 1'b0;
  logic [63:0] last_bal = '0;

  bit          op_tipo [N_REQ];
  bit          op_for  [N_REQ];
  int          op_cta  [N_REQ];
  logic [31:0] op_monto[N_REQ];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < N_REQ; k++)
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  // Reference: a whole transaction applied to the model balances in one step.
  task automatic model_txn(input int t, output bit ok, output logic [63:0] nb);
    logic [64:0] need;
    logic [64:0] s;
    logic [63:0] w;
    w = bal_m[op_cta[t]];
    need = {33'b0, op_monto[t]};
`ifdef ATM_ARB_COMISION_EN
    if (op_for[t]) need = need + 65'(COMISION);
`endif
    if (op_tipo[t]) begin
      ok = ({1'b0, w} >= need);
      nb = ok ? (w - need[63:0]) : w;
    end else begin
      s  = {1'b0, w} + {33'b0, op_monto[t]};
      ok = 1'b1;
      nb = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    end
    bal_m[op_cta[t]] = nb;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N_REQ; i++) begin
      bus.REQ_TIPO[i]                   = op_tipo[i];
      bus.REQ_FORANEA[i]                = op_for[i];
      bus.REQ_CUENTA[i*AW +: AW]        = 3'(op_cta[i]);
      bus.REQ_MONTO[i*MONTO_W +: MONTO_W] = op_monto[i];
    end
  endtask

  task automatic set_op(input int t, input bit tipo, input bit fr, input int cta, input logic [31:0] m);
    op_tipo[t] = tipo; op_for[t] = fr; op_cta[t] = cta; op_monto[t] = m;
  endtask

  // Issue requests rv and expect n grants; called at a negedge with the DUT ready to sample.
  task automatic run(input logic [3:0] rv, input int n, input bit hold, input bit pre_ld,
                     input bit busy_ld, input int ld_a, input logic [63:0] ld_v);
    int p0, gstart, last_g, endc;
    int gterm[16];
    logic [3:0] pend;
    exp_t e;
    bit ok;
    logic [63:0] nb;
    drive_ops();
    bus.REQ = rv;
    p0 = cyc + 1;
    gstart = p0;
    if (pre_ld) begin
      bus.LOAD_STB = 1'b1; bus.LOAD_CUENTA = 3'(ld_a); bus.LOAD_VALOR = ld_v;
      lq.push_back(p0);
      bal_m[ld_a] = ld_v;
      gstart = p0 + 1;
    end
    pend = rv;
    for (int k = 0; k < n; k++) begin
      gterm[k] = pick(ptr_m, pend);
      model_txn(gterm[k], ok, nb);
      e.term = gterm[k]; e.cyc = gstart + 4*k; e.ok = ok; e.bal = nb;
      gq.push_back(e);
      e.cyc = gstart + 4*k + 2;
      dq.push_back(e);
      ptr_m = (gterm[k] + 1) % N_REQ;
      if (!hold) pend[gterm[k]] = 1'b0;
    end
    last_g = gstart + 4*(n-1);
    endc = last_g + 3;
    do begin
      @(negedge CLK);
      if (pre_ld && cyc == p0) bus.LOAD_STB = 1'b0;
      if (busy_ld && cyc == gstart) begin
        bus.LOAD_STB = 1'b1; bus.LOAD_CUENTA = 3'(ld_a); bus.LOAD_VALOR = ld_v;
      end
      if (busy_ld && cyc == gstart + 1) bus.LOAD_STB = 1'b0;
      for (int k = 0; k < n; k++)
        if (!hold && cyc == gstart + 4*k) bus.REQ[gterm[k]] = 1'b0;
      if (hold && cyc == last_g) bus.REQ = '0;
    end while (cyc < endc);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"},  64'(bus.GNT), 64'd0);
    chk({tag, "_done"}, 64'(bus.DONE), 64'd0);
    chk({tag, "_ok"},   64'(bus.DONE_OK), 64'd0);
    chk({tag, "_bal"},  bus.BALANCE_OUT, 64'd0);
    chk({tag, "_ack"},  64'(bus.LOAD_ACK), 64'd0);
    chk({tag, "_busy"}, 64'(bus.OCUPADO), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  exp_t me;
  int   mc;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.GNT != '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 64'(bus.GNT), 64'd0);
        else begin
          me = gq.pop_front();
          chk("gnt_onehot", 64'(bus.GNT), 64'd1 << me.term);
          chk("gnt_cycle", 64'(cyc), 64'(me.cyc));
          chk("busy_at_gnt", 64'(bus.OCUPADO), 64'd1);
          chk("held_ok", 64'(bus.DONE_OK), 64'(last_ok));
          chk("held_bal", bus.BALANCE_OUT, last_bal);
        end
      end
      if (bus.DONE != '0) begin
        if (dq.size() == 0) chk("done_unexpected", 64'(bus.DONE), 64'd0);
        else begin
          me = dq.pop_front();
          chk("done_onehot", 64'(bus.DONE), 64'd1 << me.term);
          chk("done_cycle", 64'(cyc), 64'(me.cyc));
          chk("done_ok", 64'(bus.DONE_OK), 64'(me.ok));
          chk("done_bal", bus.BALANCE_OUT, me.bal);
          last_ok = me.ok;
          last_bal = me.bal;
        end
      end
      if (bus.LOAD_ACK) begin
        if (lq.size() == 0) chk("ack_unexpected", 64'd1, 64'd0);
        else begin
          mc = lq.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(mc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] rv;
    logic [63:0] lv;
    int pa;
    for (int c = 0; c < N_CUENTAS; c++) bal_m[c] = '0;
    for (int i = 0; i < N_REQ; i++) set_op(i, 1'b0, 1'b0, 0, 32'd0);
    bus.REQ = '0; bus.LOAD_STB = 1'b0; bus.LOAD_CUENTA = '0; bus.LOAD_VALOR = '0;
    drive_ops();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk_outputs_zero("reset");
    RESET = 1'b0;

    // All four requesting continuously: 0,1,2,3,0 at 4-cycle spacing.
    for (int i = 0; i < N_REQ; i++) set_op(i, 1'b0, 1'b0, 5, 32'(i + 1));
    run(4'b1111, 5, 1'b1, 1'b0, 1'b0, 0, 64'd0);

    // Withdrawal with funds.
    set_op(0, 1'b1, 1'b0, 2, 32'd200);
    run(4'b0001, 1, 1'b0, 1'b1, 1'b0, 2, 64'd500);
    // Insufficient funds, then exact balance.
    set_op(1, 1'b1, 1'b0, 1, 32'd150);
    run(4'b0010, 1, 1'b0, 1'b1, 1'b0, 1, 64'd100);
    set_op(1, 1'b1, 1'b0, 1, 32'd100);
    run(4'b0010, 1, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    // Deposit saturation; the load shares the cycle with the request and wins.
    set_op(2, 1'b0, 1'b0, 3, 32'd20);
    run(4'b0100, 1, 1'b0, 1'b1, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FFF6);
    // Load while busy must be ignored.
    set_op(3, 1'b0, 1'b0, 2, 32'd5);
    run(4'b1000, 1, 1'b0, 1'b0, 1'b1, 2, 64'd999);
    set_op(3, 1'b1, 1'b0, 2, 32'd0);
    run(4'b1000, 1, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    // Foreign-card withdrawals near the balance.
    set_op(0, 1'b1, 1'b1, 0, 32'd99);
    run(4'b0001, 1, 1'b0, 1'b1, 1'b0, 0, 64'd100);
    set_op(0, 1'b1, 1'b1, 0, 32'd98);
    run(4'b0001, 1, 1'b0, 1'b1, 1'b0, 0, 64'd100);
    // Two terminals on the same account are serialised.
    set_op(1, 1'b1, 1'b0, 6, 32'd70);
    set_op(2, 1'b1, 1'b0, 6, 32'd70);
    run(4'b0110, 2, 1'b0, 1'b1, 1'b0, 6, 64'd100);

    // Reset during VERIFICAR of a deposit.
    set_op(1, 1'b0, 1'b0, 4, 32'd50);
    drive_ops();
    bus.REQ = 4'b0010;
    pa = cyc + 1;
    me.term = 1; me.cyc = pa; me.ok = 1'b0; me.bal = '0;
    gq.push_back(me);
    while (cyc < pa) @(negedge CLK);
    bus.REQ = '0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    for (int c = 0; c < N_CUENTAS; c++) bal_m[c] = '0;
    ptr_m = 0; last_ok = 1'b0; last_bal = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    for (int c = 0; c < N_CUENTAS; c++) begin
      set_op(c % N_REQ, 1'b1, 1'b0, c, 32'd0);
      run(4'(1 << (c % N_REQ)), 1, 1'b0, 1'b0, 1'b0, 0, 64'd0);
    end

    // Randomised mix of operations, accounts, amounts and contention.
    for (int it = 0; it < 30; it++) begin
      rv = 4'($urandom_range(1, 15));
      for (int i = 0; i < N_REQ; i++)
        set_op(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 400));
      lv = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 500)))
                                       : 64'($urandom_range(0, 1000));
      run(rv, $countones(rv), 1'b0, ($urandom_range(0, 2) == 0), 1'b0,
          int'($urandom_range(0, 7)), lv);
    end

    repeat (4) @(negedge CLK);
    chk("gnt_queue_empty", 64'(gq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("ack_queue_empty", 64'(lq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
